// File: rtl/cache_mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter_if
// Bus bundle between the icache, the dcache, the shared RAM port and the
// arbiter that multiplexes them.
//   icache side : iREN, iaddr (to arbiter)      iwait, iload (from arbiter)
//   dcache side : dREN, dWEN, daddr, dstore     dwait, dload
//   RAM side    : ramload, ram_ready (to arb)   ramREN, ramWEN, ramaddr,
//                                               ramstore (from arbiter)
//   status      : gnt_d (from arbiter, registered dcache ownership)
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding environment (both caches plus the memory model)
// ----------------------------------------------------------------------------
interface cache_mem_arbiter_if;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ram_ready;

    logic        gnt_d;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               gnt_d
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore,
               gnt_d
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// ----------------------------------------------------------------------------
// cache_mem_arbiter
// Shares the single RAM port between the icache and the dcache. One cache is
// granted at a time and the grant is held for up to MAX_BURST RAM beats so a
// block fill or writeback is never split. Address, data and wait are routed
// combinationally between the granted cache and RAM.
// Parameters:
//   MAX_BURST  - RAM beats a grant may hold before it is released
//   D_PRIORITY - 1: dcache wins every tie, 0: round-robin on ties
// Ports:
//   CLK - clock, all state updates on the rising edge
//   RST - synchronous active-high reset
//   bus - cache/RAM bundle (slave modport), see cache_mem_arbiter_if
// ----------------------------------------------------------------------------
module cache_mem_arbiter #(
    parameter int MAX_BURST  = 2,
    parameter bit D_PRIORITY = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST,
    cache_mem_arbiter_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SRV_I = 2'd1,
        SRV_D = 2'd2
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic             last_gnt_d_r;   // 1: the last finished grant was dcache
    logic             gnt_d_r;

    logic             ireq_s;
    logic             dreq_s;
    logic             pick_d_s;

    logic             ramREN_s;
    logic             ramWEN_s;
    logic [31:0]      ramaddr_s;
    logic [31:0]      ramstore_s;
    logic             iwait_s;
    logic             dwait_s;
    logic [31:0]      iload_s;
    logic [31:0]      dload_s;

    assign ireq_s = bus.iREN;
    assign dreq_s = bus.dREN | bus.dWEN;

    // Tie resolution: dcache wins on its own, on fixed priority, or when the
    // icache held the port last.
    assign pick_d_s = dreq_s & (~ireq_s | D_PRIORITY | ~last_gnt_d_r);

    // Grant FSM with burst accounting; owner drop or last beat releases.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r      <= IDLE;
            beat_cnt_r   <= CNT_ZERO;
            last_gnt_d_r <= 1'b0;
            gnt_d_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    beat_cnt_r <= CNT_ZERO;
                    if (pick_d_s) begin
                        state_r <= SRV_D;
                        gnt_d_r <= 1'b1;
                    end else if (ireq_s) begin
                        state_r <= SRV_I;
                        gnt_d_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                        gnt_d_r <= 1'b0;
                    end
                end
                SRV_D: begin
                    if (!dreq_s || (bus.ram_ready && beat_cnt_r == LAST_BEAT)) begin
                        state_r      <= IDLE;
                        beat_cnt_r   <= CNT_ZERO;
                        last_gnt_d_r <= 1'b1;
                        gnt_d_r      <= 1'b0;
                    end else if (bus.ram_ready) begin
                        beat_cnt_r <= beat_cnt_r + CNT_ONE;
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                SRV_I: begin
                    if (!ireq_s || (bus.ram_ready && beat_cnt_r == LAST_BEAT)) begin
                        state_r      <= IDLE;
                        beat_cnt_r   <= CNT_ZERO;
                        last_gnt_d_r <= 1'b0;
                        gnt_d_r      <= 1'b0;
                    end else if (bus.ram_ready) begin
                        beat_cnt_r <= beat_cnt_r + CNT_ONE;
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    beat_cnt_r <= CNT_ZERO;
                    gnt_d_r    <= 1'b0;
                end
            endcase
        end
    end

    // Route strobes, address, data and wait between the granted cache and RAM.
    always_comb begin
        ramREN_s   = 1'b0;
        ramWEN_s   = 1'b0;
        ramaddr_s  = 32'h0000_0000;
        ramstore_s = 32'h0000_0000;
        iwait_s    = 1'b1;
        dwait_s    = 1'b1;
        iload_s    = 32'h0000_0000;
        dload_s    = 32'h0000_0000;
        case (state_r)
            SRV_D: begin
                ramaddr_s  = bus.daddr;
                ramstore_s = bus.dstore;
                ramWEN_s   = bus.dWEN;
                ramREN_s   = bus.dREN & ~bus.dWEN;   // write wins when both high
                dload_s    = bus.ramload;
                // A ready arriving after the owner dropped its request is ignored.
                if (dreq_s) begin
                    dwait_s = ~bus.ram_ready;
                end else begin
                    dwait_s = 1'b1;
                end
            end
            SRV_I: begin
                ramaddr_s = bus.iaddr;
                ramREN_s  = bus.iREN;
                iload_s   = bus.ramload;
                if (ireq_s) begin
                    iwait_s = ~bus.ram_ready;
                end else begin
                    iwait_s = 1'b1;
                end
            end
            default: begin
                ramREN_s = 1'b0;
                ramWEN_s = 1'b0;
            end
        endcase
    end

    assign bus.ramREN   = ramREN_s;
    assign bus.ramWEN   = ramWEN_s;
    assign bus.ramaddr  = ramaddr_s;
    assign bus.ramstore = ramstore_s;
    assign bus.iwait    = iwait_s;
    assign bus.dwait    = dwait_s;
    assign bus.iload    = iload_s;
    assign bus.dload    = dload_s;
    assign bus.gnt_d    = gnt_d_r;

endmodule
